// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer: mode encodings, button indices, seed patterns.
package led_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShiftL = 2'd1,
    StShiftR = 2'd2,
    StFlash  = 2'd3
  } mode_e;

  localparam int unsigned BtnShiftL = 0;
  localparam int unsigned BtnShiftR = 1;
  localparam int unsigned BtnFlash  = 2;
  localparam int unsigned BtnIdle   = 3;

  localparam int unsigned MaxLeds = 32;

  // Callers truncate the result to their own LED width.
  function automatic logic [MaxLeds-1:0] seed_pattern(input mode_e mode,
                                                      input int unsigned nb_leds);
    logic [MaxLeds-1:0] seed;
    seed = '0;
    unique case (mode)
      StShiftL: seed = MaxLeds'(1);
      StShiftR: seed = MaxLeds'(1) << (nb_leds - 1);
      StFlash:  seed = (nb_leds >= MaxLeds) ? '1 : ((MaxLeds'(1) << nb_leds) - MaxLeds'(1));
      StIdle:   seed = '0;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Bundles the tick/enable/button inputs and the LED/mode outputs of the LED sequencer.
interface led_seq_ctrl_if #(
  parameter int unsigned NB_LEDS = 4,
  parameter int unsigned NB_BTN  = 4
);
  logic               i_valid;
  logic               i_enable;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;
  logic [1:0]         o_mode;

  modport master (
    output i_valid, i_enable, i_btn,
    input  o_led, o_led_r, o_led_g, o_led_b, o_mode
  );

  modport slave (
    input  i_valid, i_enable, i_btn,
    output o_led, o_led_r, o_led_g, o_led_b, o_mode
  );
endinterface

// File: rtl/btn_req_enc.sv
// Button rising-edge detector and lowest-index-wins mode request encoder.
module btn_req_enc
  import led_seq_pkg::*;
#(
  parameter int unsigned NB_BTN = 4
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic              o_req_valid,
  output mode_e             o_req_mode
);

  logic [NB_BTN-1:0] r_btn;
  logic [NB_BTN-1:0] w_rise;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_btn <= '0;
    end else begin
      r_btn <= i_btn;
    end
  end

  assign w_rise = i_btn & ~r_btn;

  always_comb begin
    o_req_valid = 1'b1;
    o_req_mode  = StIdle;
    if (w_rise[BtnShiftL]) begin
      o_req_mode = StShiftL;
    end else if (w_rise[BtnShiftR]) begin
      o_req_mode = StShiftR;
    end else if (w_rise[BtnFlash]) begin
      o_req_mode = StFlash;
    end else if (w_rise[BtnIdle]) begin
      o_req_mode = StIdle;
    end else begin
      o_req_valid = 1'b0;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: button-selected mode FSM, pattern register, flash counter and colour gating.
// Optional build macro LED_SEQ_BOUNCE_EN makes the shift modes bounce at the ends instead of wrap.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned NB_LEDS  = 4,
  parameter int unsigned NB_BTN   = 4,
  parameter int unsigned NB_FLASH = 3
) (
  input logic           clock,
  input logic           i_reset,
  led_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(2 * NB_FLASH);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * NB_FLASH - 1);

  mode_e              r_state, w_state_d;
  logic [NB_LEDS-1:0] r_pattern, w_pattern_d;
  logic [CntW-1:0]    r_flash_cnt, w_flash_cnt_d;
  logic               w_req_valid;
  mode_e              w_req_mode;
  logic [NB_LEDS-1:0] w_seed;
  logic               w_tick;
`ifdef LED_SEQ_BOUNCE_EN
  logic               r_dir_left, w_dir_left_d;
`endif

  btn_req_enc #(
    .NB_BTN (NB_BTN)
  ) u_btn_req_enc (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_btn       (bus.i_btn),
    .o_req_valid (w_req_valid),
    .o_req_mode  (w_req_mode)
  );

  assign w_seed = NB_LEDS'(seed_pattern(w_req_mode, NB_LEDS));
  assign w_tick = bus.i_valid & bus.i_enable;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_pattern   <= '0;
      r_flash_cnt <= '0;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir_left  <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_d;
      r_pattern   <= w_pattern_d;
      r_flash_cnt <= w_flash_cnt_d;
`ifdef LED_SEQ_BOUNCE_EN
      r_dir_left  <= w_dir_left_d;
`endif
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pattern_d   = r_pattern;
    w_flash_cnt_d = r_flash_cnt;
`ifdef LED_SEQ_BOUNCE_EN
    w_dir_left_d  = r_dir_left;
`endif
    // A mode request wins over a tick in the same cycle; that tick is dropped.
    if (w_req_valid) begin
      w_state_d     = w_req_mode;
      w_pattern_d   = w_seed;
      w_flash_cnt_d = '0;
`ifdef LED_SEQ_BOUNCE_EN
      w_dir_left_d  = (w_req_mode != StShiftR);
`endif
    end else if (w_tick) begin
      unique case (r_state)
`ifdef LED_SEQ_BOUNCE_EN
        StShiftL, StShiftR: begin
          if (r_dir_left) begin
            if (r_pattern[NB_LEDS-1]) begin
              w_pattern_d  = r_pattern >> 1;
              w_dir_left_d = 1'b0;
            end else begin
              w_pattern_d = r_pattern << 1;
            end
          end else begin
            if (r_pattern[0]) begin
              w_pattern_d  = r_pattern << 1;
              w_dir_left_d = 1'b1;
            end else begin
              w_pattern_d = r_pattern >> 1;
            end
          end
        end
`else
        StShiftL: w_pattern_d = {r_pattern[NB_LEDS-2:0], r_pattern[NB_LEDS-1]};
        StShiftR: w_pattern_d = {r_pattern[0], r_pattern[NB_LEDS-1:1]};
`endif
        StFlash: begin
          if (r_flash_cnt == LastCnt) begin
            w_state_d     = StIdle;
            w_pattern_d   = '0;
            w_flash_cnt_d = '0;
          end else begin
            w_pattern_d   = ~r_pattern;
            w_flash_cnt_d = r_flash_cnt + 1'b1;
          end
        end
        StIdle: w_pattern_d = '0;
      endcase
    end
  end

  assign bus.o_led   = r_pattern;
  assign bus.o_led_r = (r_state == StShiftL) ? r_pattern : '0;
  assign bus.o_led_g = (r_state == StShiftR) ? r_pattern : '0;
  assign bus.o_led_b = (r_state == StFlash)  ? r_pattern : '0;
  assign bus.o_mode  = r_state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected outputs, a negedge monitor checks them.
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_seq_ctrl_if #(.NB_LEDS(4), .NB_BTN(4)) bus ();

  led_seq_ctrl #(
    .NB_LEDS  (4),
    .NB_BTN   (4),
    .NB_FLASH (2)
  ) dut (
    .clock   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [3:0]  led;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] shl_t  [5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] shr_t  [10] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000,
                              4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
  logic [3:0] fl_t   [4]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
  logic [1:0] flm_t  [4]  = '{2'd3, 2'd3, 2'd3, 2'd0};
`ifdef LED_SEQ_BOUNCE_EN
  logic [3:0] mv_t   [6]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
`else
  logic [3:0] mv_t   [6]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
`endif

  task automatic step(input logic r, input logic v, input logic e, input logic [3:0] b,
                      input string name, input logic [3:0] led, input logic [1:0] mode);
    exp_t x;
    rst          = r;
    bus.i_valid  = v;
    bus.i_enable = e;
    bus.i_btn    = b;
    @(posedge clk);
    #1;
    x.name = name;
    x.cyc  = cyc;
    x.led  = led;
    x.mode = mode;
    sb_q.push_back(x);
  endtask

  // Monitor: every entry due in the current cycle is popped and compared.
  initial begin
    exp_t       e;
    logic [17:0] got, want;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        want = {e.mode, e.led,
                (e.mode == 2'd1) ? e.led : 4'b0000,
                (e.mode == 2'd2) ? e.led : 4'b0000,
                (e.mode == 2'd3) ? e.led : 4'b0000};
        got  = {bus.o_mode, bus.o_led, bus.o_led_r, bus.o_led_g, bus.o_led_b};
        checks++;
        if (e.cyc != cyc || got !== want) begin
          errors++;
          $display("FAIL %s cyc=%0d {mode,led,r,g,b} got=%h want=%h", e.name, cyc, got, want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

  initial begin
    step(1'b1, 1'b1, 1'b1, 4'b0000, "rst0", 4'b0000, 2'd0);
    step(1'b1, 1'b1, 1'b1, 4'b0000, "rst1", 4'b0000, 2'd0);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "idle_tick0", 4'b0000, 2'd0);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "idle_tick1", 4'b0000, 2'd0);

    step(1'b0, 1'b0, 1'b1, 4'b0001, "shl_seed", 4'b0001, 2'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, "shl_tick", shl_t[i], 2'd1);

    // Held button: only the first cycle restarts, later ticks advance.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 4'b0010, "shr_held", shr_t[i], 2'd2);
    step(1'b0, 1'b0, 1'b1, 4'b0000, "shr_hold", 4'b0100, 2'd2);

    step(1'b0, 1'b0, 1'b1, 4'b0100, "fl_seed", 4'b1111, 2'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, "fl_tick", fl_t[i], flm_t[i]);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "fl_done_idle", 4'b0000, 2'd0);

    step(1'b0, 1'b0, 1'b1, 4'b0001, "co_seed", 4'b0001, 2'd1);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "co_tick0", 4'b0010, 2'd1);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "co_tick1", 4'b0100, 2'd1);
    step(1'b0, 1'b1, 1'b1, 4'b0010, "co_req_tick", 4'b1000, 2'd2);
    step(1'b0, 1'b0, 1'b1, 4'b0000, "co_after", 4'b1000, 2'd2);

    step(1'b0, 1'b0, 1'b1, 4'b0101, "prio_0_2", 4'b0001, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, "frozen", 4'b0001, 2'd1);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "unfrozen", 4'b0010, 2'd1);
    step(1'b0, 1'b0, 1'b0, 4'b0010, "en0_mode", 4'b1000, 2'd2);

    step(1'b0, 1'b0, 1'b1, 4'b0100, "fl2_seed", 4'b1111, 2'd3);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "fl2_tick0", 4'b0000, 2'd3);
    step(1'b0, 1'b1, 1'b1, 4'b0000, "fl2_tick1", 4'b1111, 2'd3);
    step(1'b1, 1'b1, 1'b1, 4'b0000, "rst_midflash", 4'b0000, 2'd0);

    step(1'b1, 1'b0, 1'b1, 4'b0001, "rst_btn_held", 4'b0000, 2'd0);
    step(1'b0, 1'b0, 1'b1, 4'b0001, "post_rst_rise", 4'b0001, 2'd1);
    step(1'b0, 1'b1, 1'b1, 4'b0001, "held_tick", 4'b0010, 2'd1);
    step(1'b0, 1'b0, 1'b1, 4'b1000, "idle_req", 4'b0000, 2'd0);

    step(1'b0, 1'b0, 1'b1, 4'b0001, "mv_seed", 4'b0001, 2'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, "mv_tick", mv_t[i], 2'd1);

    rst = 1'b0; bus.i_valid = 1'b0; bus.i_btn = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d entries left want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
